// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: MEM-stage sequencing state encodings and defaults.
package mem_stage_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2,
    S_HALTED  = 2'd3
  } state_t;
  localparam int TIMEOUT_DEF = 255;
  localparam int TCNT_W = 8;
endpackage

// File: rtl/mem_stage_ctrl_sat_counter.sv
// sat_counter: width-parameterised saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage load/store sequencer with stall, bubble, halt and timeout.
// Optional MEM_STALL_PERF_EN adds the stallCount saturating stall-cycle counter.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memRead,
  input  logic          memWrite,
  input  logic          haltIn,
  input  logic          redirect,
  input  logic          memDone,
  input  logic [DW-1:0] memData,
  output logic          memEn,
  output logic          stallPipe,
  output logic          bubbleMW,
  output logic          flushFront,
  output logic [DW-1:0] loadData,
  output logic          haltOut,
`ifdef MEM_STALL_PERF_EN
  output logic          memErr,
  output logic [15:0]   stallCount
`else
  output logic          memErr
`endif
);
  state_t state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;
  logic halt_q, halt_d, err_q, err_d, access, expire;
  logic [TCNT_W-1:0] tcnt;
  always_comb begin
    access     = state_q == S_IDLE && (memRead || memWrite) && !haltIn;
    expire     = state_q == S_WAIT && !memDone && tcnt == TCNT_W'(TIMEOUT - 1);
    memEn      = access;
    stallPipe  = (access && !memDone) || state_q == S_WAIT || state_q == S_HALTED;
    bubbleMW   = stallPipe;
    flushFront = redirect && !stallPipe;
    loadData   = state_q == S_RELEASE ? hold_q : memData;
    hold_d     = (state_q == S_WAIT && memDone) ? memData : hold_q;
    state_d    = state_q == S_IDLE    ? (haltIn ? S_HALTED : (access && !memDone) ? S_WAIT : S_IDLE)
               : state_q == S_WAIT    ? (memDone ? S_RELEASE : expire ? S_HALTED : S_WAIT)
               : state_q == S_RELEASE ? S_IDLE : S_HALTED;
    halt_d     = halt_q || state_d == S_HALTED;
    err_d      = err_q || expire;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  assign haltOut = halt_q;
  assign memErr  = err_q;
  // Held at zero outside WAIT so every new wait starts counting from a clean slate.
  sat_counter #(.W(TCNT_W)) u_tcnt (
    .clk(clk), .rst(rst), .clr(state_q != S_WAIT), .inc(state_q == S_WAIT), .q(tcnt)
  );
`ifdef MEM_STALL_PERF_EN
  sat_counter #(.W(16)) u_perf (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(stallPipe && state_q != S_HALTED), .q(stallCount)
  );
`endif
endmodule
